// File: rtl/conv1d_pkg.sv
// Shared definitions for the 1D convolution engine: sequencer states and
// the default geometry used by the kernel store, MAC and sequencer.
package conv1d_pkg;

  localparam int TAPS_DEF    = 3;
  localparam int LEN_W_DEF   = 16;
  localparam int MAC_LAT_DEF = 2;
  localparam int IDX_W_DEF   = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    FILL,
    RUN,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/conv1d_sequencer_if.sv
// Host/datapath-facing control bundle of the convolution sequencer.
// The sequencer takes the slave view; whoever drives jobs and beats takes master.
interface conv1d_sequencer_if #(
  parameter int LEN_W = conv1d_pkg::LEN_W_DEF,
  parameter int IDX_W = conv1d_pkg::IDX_W_DEF
) ();

  logic             start;
  logic [LEN_W-1:0] n_samples;
  logic             k_valid;
  logic             k_ready;
  logic             k_wr_en;
  logic [IDX_W-1:0] k_wr_idx;
  logic             x_valid;
  logic             x_ready;
  logic             win_shift;
  logic             mac_en;
  logic             y_valid;
  logic             y_last;
  logic             busy;
  logic             done;
  logic             err_len;

  modport master (
    output start, n_samples, k_valid, x_valid,
    input  k_ready, k_wr_en, k_wr_idx, x_ready, win_shift, mac_en,
           y_valid, y_last, busy, done, err_len
  );

  modport slave (
    input  start, n_samples, k_valid, x_valid,
    output k_ready, k_wr_en, k_wr_idx, x_ready, win_shift, mac_en,
           y_valid, y_last, busy, done, err_len
  );

endinterface

// File: rtl/conv1d_valid_pipe.sv
// DEPTH-stage shift register carrying {last, valid} alongside the MAC,
// so the output strobes line up with the datapath result.
module conv1d_valid_pipe #(
  parameter int DEPTH = conv1d_pkg::MAC_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [1:0] stage [DEPTH];

  // Clearing every stage on reset drops results of an abandoned job in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= 2'b00;
      end
    end else begin
      stage[0] <= {in_last, in_valid};
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_valid = stage[DEPTH-1][0];
  assign out_last  = stage[DEPTH-1][1];

endmodule

// File: rtl/conv1d_sequencer.sv
// Control FSM for the 1D convolution engine: kernel load, window fill,
// streaming MAC phase, pipeline flush and job completion.
module conv1d_sequencer
  import conv1d_pkg::*;
#(
  parameter int TAPS    = TAPS_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input logic              clk,
  input logic              reset,
  conv1d_sequencer_if.slave bus
);

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] n_lat;
  logic [LEN_W-1:0] s_cnt;
  logic [IDX_W-1:0] k_cnt;
  logic             err_q;
  logic             start_ok;
  logic             k_ready;
  logic             x_ready;
  logic             k_wr_en;
  logic             win_shift;
  logic             mac_en;
  logic             last_beat;
  logic             pipe_valid;
  logic             pipe_last;

  assign start_ok = (state == IDLE) && bus.start && (bus.n_samples >= LEN_W'(TAPS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Ready lines decode only the registered state; strobes are ready & valid.
  always_comb begin
    state_next = state;
    k_ready    = 1'b0;
    x_ready    = 1'b0;
    k_wr_en    = 1'b0;
    win_shift  = 1'b0;
    mac_en     = 1'b0;
    last_beat  = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = LOAD_K;
        end
      end
      LOAD_K: begin
        k_ready = 1'b1;
        k_wr_en = bus.k_valid;
        if (bus.k_valid && (k_cnt == IDX_W'(TAPS - 1))) begin
          state_next = (TAPS > 1) ? FILL : RUN;
        end
      end
      FILL: begin
        x_ready   = 1'b1;
        win_shift = bus.x_valid;
        if (bus.x_valid && (s_cnt == LEN_W'(TAPS - 2))) begin
          state_next = RUN;
        end
      end
      RUN: begin
        x_ready   = 1'b1;
        win_shift = bus.x_valid;
        mac_en    = bus.x_valid;
        last_beat = bus.x_valid && (s_cnt == (n_lat - LEN_W'(1)));
        if (last_beat) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (pipe_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // s_cnt counts samples from the first FILL beat, so index N-1 marks the last.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_lat <= '0;
      s_cnt <= '0;
      k_cnt <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && bus.start && (bus.n_samples < LEN_W'(TAPS));
      if (start_ok) begin
        n_lat <= bus.n_samples;
        s_cnt <= '0;
        k_cnt <= '0;
      end else if (k_wr_en) begin
        k_cnt <= (k_cnt == IDX_W'(TAPS - 1)) ? '0 : k_cnt + IDX_W'(1);
      end else if (win_shift) begin
        s_cnt <= s_cnt + LEN_W'(1);
      end
    end
  end

  conv1d_valid_pipe #(
    .DEPTH (MAC_LAT)
  ) u_valid_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (mac_en),
    .in_last   (last_beat),
    .out_valid (pipe_valid),
    .out_last  (pipe_last)
  );

  assign bus.k_ready   = k_ready;
  assign bus.x_ready   = x_ready;
  assign bus.k_wr_en   = k_wr_en;
  assign bus.k_wr_idx  = k_cnt;
  assign bus.win_shift = win_shift;
  assign bus.mac_en    = mac_en;
  assign bus.y_valid   = pipe_valid;
  assign bus.y_last    = pipe_last;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.err_len   = err_q;

endmodule

// File: tb/tb_conv1d_sequencer.sv
// Scoreboard bench for conv1d_sequencer: the driver predicts every strobe
// from the job rules, a negedge monitor pops and compares as the DUT emits.
module tb_conv1d_sequencer;

  localparam int TAPS    = 3;
  localparam int LEN_W   = 16;
  localparam int MAC_LAT = 2;
  localparam int IDX_W   = 2;
  localparam int BOUND   = 20;

  typedef struct { int cyc; int idx; } kexp_t;
  typedef struct { int cyc; bit mac;  } sexp_t;
  typedef struct { int cyc; bit last; } yexp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;

  kexp_t kq[$];
  sexp_t sq[$];
  yexp_t yq[$];
  int    dq[$];
  int    eq[$];

  conv1d_sequencer_if #(.LEN_W(LEN_W), .IDX_W(IDX_W)) bus_if ();

  conv1d_sequencer #(
    .TAPS    (TAPS),
    .LEN_W   (LEN_W),
    .MAC_LAT (MAC_LAT),
    .IDX_W   (IDX_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input bit st, input int n, input bit kv, input bit xv);
    bus_if.start     = st;
    bus_if.n_samples = LEN_W'(n);
    bus_if.k_valid   = kv;
    bus_if.x_valid   = xv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkQueuesEmpty(input string tag);
    checkOutput({tag, "_kq_left"}, kq.size(), 0);
    checkOutput({tag, "_sq_left"}, sq.size(), 0);
    checkOutput({tag, "_yq_left"}, yq.size(), 0);
    checkOutput({tag, "_dq_left"}, dq.size(), 0);
    checkOutput({tag, "_eq_left"}, eq.size(), 0);
  endtask

  // An abandoned job owes nothing: forget its expectations, then all outputs idle.
  task automatic resetDut();
    applyStimulus(0, 0, 0, 0);
    reset = 1'b1;
    step();
    kq.delete(); sq.delete(); yq.delete(); dq.delete(); eq.delete();
    checkOutput("rst_busy",      bus_if.busy,      0);
    checkOutput("rst_done",      bus_if.done,      0);
    checkOutput("rst_err_len",   bus_if.err_len,   0);
    checkOutput("rst_y_valid",   bus_if.y_valid,   0);
    checkOutput("rst_y_last",    bus_if.y_last,    0);
    checkOutput("rst_k_ready",   bus_if.k_ready,   0);
    checkOutput("rst_x_ready",   bus_if.x_ready,   0);
    checkOutput("rst_k_wr_idx",  bus_if.k_wr_idx,  0);
    checkOutput("rst_mac_en",    bus_if.mac_en,    0);
    reset = 1'b0;
    repeat (MAC_LAT + 3) step();
    checkOutput("post_rst_busy", bus_if.busy, 0);
  endtask

  // mode: 0 continuous, 1 x_valid toggling plus a kernel gap, 2 random stalls.
  task automatic runJob(input int n, input int mode, input bit illegal,
                        input bit busy_start, input int abort_after);
    int wait_cnt;
    int macs;
    macs = 0;
    applyStimulus(1, n, 0, illegal);
    if (n < TAPS) begin
      eq.push_back(cyc + 1);
      step();
      applyStimulus(0, 0, 0, 0);
      checkOutput("busy_after_bad_start", bus_if.busy, 0);
      step();
      checkOutput("busy_still_idle", bus_if.busy, 0);
      checkQueuesEmpty("errjob");
      return;
    end
    step();
    applyStimulus(0, 0, 0, illegal);
    checkOutput("busy_load", bus_if.busy, 1);

    for (int w = 0; w < TAPS; w++) begin
      if ((mode == 1 && w == 1) || (mode == 2 && $urandom_range(0, 3) == 0)) begin
        repeat ((mode == 1) ? 3 : 1) begin
          bus_if.k_valid = 1'b0;
          bus_if.x_valid = illegal;
          checkOutput("k_ready_gap", bus_if.k_ready, 1);
          checkOutput("x_ready_load_gap", bus_if.x_ready, 0);
          step();
        end
      end
      bus_if.k_valid = 1'b1;
      bus_if.x_valid = illegal;
      wait_cnt = 0;
      while (!bus_if.k_ready && wait_cnt < BOUND) begin
        step();
        wait_cnt++;
      end
      if (!bus_if.k_ready) begin
        checkOutput("k_ready_timeout", 0, 1);
        resetDut();
        return;
      end
      checkOutput("x_ready_load", bus_if.x_ready, 0);
      kq.push_back('{cyc, w});
      step();
    end
    bus_if.k_valid = 1'b0;
    bus_if.x_valid = 1'b0;

    for (int i = 0; i < n; i++) begin
      if ((mode == 1 && (i % 2) == 1) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        bus_if.x_valid = 1'b0;
        bus_if.k_valid = illegal;
        checkOutput("x_ready_stream_idle", bus_if.x_ready, 1);
        step();
      end
      bus_if.x_valid = 1'b1;
      bus_if.k_valid = illegal;
      wait_cnt = 0;
      while (!bus_if.x_ready && wait_cnt < BOUND) begin
        step();
        wait_cnt++;
      end
      if (!bus_if.x_ready) begin
        checkOutput("x_ready_timeout", 0, 1);
        resetDut();
        return;
      end
      checkOutput("k_ready_stream", bus_if.k_ready, 0);
      if (busy_start && i == TAPS) begin
        bus_if.start     = 1'b1;
        bus_if.n_samples = LEN_W'($urandom_range(0, 2));
      end
      sq.push_back('{cyc, (i >= TAPS - 1)});
      if (i >= TAPS - 1) begin
        yq.push_back('{cyc + MAC_LAT, (i == n - 1)});
        macs++;
      end
      if (i == n - 1) dq.push_back(cyc + MAC_LAT + 1);
      step();
      bus_if.start = 1'b0;
      if (abort_after != 0 && macs == abort_after) begin
        resetDut();
        return;
      end
    end

    bus_if.x_valid = illegal;
    bus_if.k_valid = 1'b0;
    repeat (MAC_LAT) begin
      checkOutput("x_ready_flush", bus_if.x_ready, 0);
      checkOutput("busy_flush", bus_if.busy, 1);
      step();
    end
    checkOutput("busy_at_done", bus_if.busy, 1);
    checkOutput("x_ready_done", bus_if.x_ready, 0);
    applyStimulus(1, 5, 0, illegal);
    step();
    applyStimulus(0, 0, 0, 0);
    checkOutput("busy_after_done", bus_if.busy, 0);
    step();
    checkOutput("start_in_done_ignored", bus_if.busy, 0);
    checkQueuesEmpty("job");
  endtask

  // Monitor: every strobe the DUT raises must match the oldest prediction.
  always @(negedge clk) begin
    kexp_t ke;
    sexp_t se;
    yexp_t ye;
    int    de;
    if (!reset) begin
      if (bus_if.k_wr_en) begin
        if (kq.size() == 0) checkOutput("k_wr_en_unexpected", 1, 0);
        else begin
          ke = kq.pop_front();
          checkOutput("k_wr_cycle", cyc, ke.cyc);
          checkOutput("k_wr_idx", bus_if.k_wr_idx, ke.idx);
        end
      end
      if (bus_if.win_shift) begin
        if (sq.size() == 0) checkOutput("win_shift_unexpected", 1, 0);
        else begin
          se = sq.pop_front();
          checkOutput("win_shift_cycle", cyc, se.cyc);
          checkOutput("mac_en", bus_if.mac_en, se.mac);
        end
      end else if (bus_if.mac_en) begin
        checkOutput("mac_en_without_shift", 1, 0);
      end
      if (bus_if.y_valid) begin
        if (yq.size() == 0) checkOutput("y_valid_unexpected", 1, 0);
        else begin
          ye = yq.pop_front();
          checkOutput("y_valid_cycle", cyc, ye.cyc);
          checkOutput("y_last", bus_if.y_last, ye.last);
        end
      end else if (bus_if.y_last) begin
        checkOutput("y_last_without_valid", 1, 0);
      end
      if (bus_if.done) begin
        if (dq.size() == 0) checkOutput("done_unexpected", 1, 0);
        else begin
          de = dq.pop_front();
          checkOutput("done_cycle", cyc, de);
        end
      end
      if (bus_if.err_len) begin
        if (eq.size() == 0) checkOutput("err_len_unexpected", 1, 0);
        else begin
          de = eq.pop_front();
          checkOutput("err_len_cycle", cyc, de);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    applyStimulus(0, 0, 0, 0);
    repeat (3) step();
    checkOutput("reset_busy",     bus_if.busy,     0);
    checkOutput("reset_done",     bus_if.done,     0);
    checkOutput("reset_k_ready",  bus_if.k_ready,  0);
    checkOutput("reset_x_ready",  bus_if.x_ready,  0);
    checkOutput("reset_y_valid",  bus_if.y_valid,  0);
    checkOutput("reset_k_wr_idx", bus_if.k_wr_idx, 0);
    checkOutput("reset_err_len",  bus_if.err_len,  0);
    reset = 1'b0;
    step();

    $display("[TB] nominal job N=8");
    runJob(8, 0, 0, 0, 0);
    $display("[TB] stalled handshakes N=5");
    runJob(5, 1, 0, 0, 0);
    $display("[TB] length errors and minimum job");
    runJob(2, 0, 0, 0, 0);
    runJob(0, 0, 0, 0, 0);
    runJob(3, 0, 0, 0, 0);
    $display("[TB] start while busy");
    runJob(10, 0, 0, 1, 0);
    $display("[TB] reset mid-job then N=4");
    runJob(8, 0, 0, 0, 2);
    runJob(4, 0, 0, 0, 0);
    $display("[TB] illegal beats");
    runJob(6, 0, 1, 0, 0);
    runJob(7, 1, 1, 0, 0);
    $display("[TB] randomized jobs");
    for (int j = 0; j < 20; j++) begin
      runJob($urandom_range(0, 24), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 0);
    end
    runJob(300, 2, 1, 1, 0);
    checkQueuesEmpty("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv1d_sequencer.md
Name: conv1d_sequencer

Overview:
- Top-level control FSM for the 1D convolution engine.
- Per job, sequences three phases:
  - load TAPS kernel words into the kernel store;
  - prime the sample window with TAPS-1 samples;
  - stream the remaining samples through the MAC, one output per accepted sample.
- Generates kernel-write strobes, window-shift/MAC enables, output valid/last (aligned to MAC latency) and job done.
- Sits between the host-side start/length registers and the kernel store, window shift register and MAC datapath. Carries no data itself.

Parameters:
- TAPS, 3, kernel length; also the number of window-fill beats plus 1.
- LEN_W, 16, width of the sample-count field.
- MAC_LAT, 2, cycles from mac_en to the result on the datapath output; must be at least 1.
- IDX_W, 2, width of k_wr_idx; must satisfy 2**IDX_W >= TAPS.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle job request; ignored while busy.
- n_samples  in  LEN_W  input sample count N, sampled on accepted start.
- k_valid  in  1  kernel word present on the kernel bus.
- k_ready  out  1  sequencer accepts a kernel word.
- k_wr_en  out  1  write strobe to the kernel store.
- k_wr_idx  out  IDX_W  kernel store address for this write.
- x_valid  in  1  input sample present.
- x_ready  out  1  sequencer accepts a sample.
- win_shift  out  1  shift the accepted sample into the window.
- mac_en  out  1  compute one output from the current window plus the new sample.
- y_valid  out  1  datapath output valid.
- y_last  out  1  final output of the job, asserted with y_valid.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at job completion.
- err_len  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: all state and registers clear synchronously, regardless of FSM phase; the FSM goes to IDLE.
  - Reset values: all outputs 0, k_wr_idx 0, counters 0, MAC_LAT valid/last pipeline cleared.
  - Reset mid-job abandons the job. No done or y_valid is produced for it, including results still in flight in the pipeline.
- States: IDLE, LOAD_K, FILL, RUN, FLUSH, DONE.
- k_ready and x_ready are pure decodes of the registered state, independent of k_valid/x_valid.
- Kernel fire = k_valid & k_ready. Sample fire = x_valid & x_ready.
- k_wr_en, win_shift and mac_en are combinational and asserted in the same cycle as the corresponding fire.
- IDLE:
  - start with n_samples >= TAPS: latch N, clear counters, go to LOAD_K.
  - start with n_samples < TAPS: err_len pulses the next cycle and the FSM stays in IDLE.
- LOAD_K: k_ready=1.
  - Each kernel fire: k_wr_en=1, k_wr_idx = kernel count, then the count increments.
  - On the fire with count == TAPS-1: go to FILL.
  - Cycles without k_valid stall with no strobe.
- FILL: x_ready=1.
  - Each fire: win_shift=1, mac_en=0.
  - After TAPS-1 fires: go to RUN.
- RUN: x_ready=1.
  - Each fire: win_shift=1 and mac_en=1, and the sample counter increments.
  - The fire carrying sample index N-1 (0-based, counted from the first FILL beat) is the last. It tags the pipeline with last=1; go to FLUSH.
- FLUSH: x_ready=0. Wait until the last tag exits the MAC_LAT pipeline, then go to DONE.
- DONE: done=1 for exactly one cycle; return to IDLE. busy=0 from the cycle after DONE.
- Output pipeline:
  - y_valid equals mac_en delayed exactly MAC_LAT cycles.
  - y_last equals the last tag delayed MAC_LAT cycles.
  - Output count per job is exactly N-TAPS+1.
  - There is no downstream backpressure; the consumer must always accept.
- Timing: done asserts in the cycle after y_last, i.e. MAC_LAT+1 cycles after the final mac_en.
- Widths: sample counter is LEN_W bits; N = 2**LEN_W-1 must complete without wrap. Kernel counter is IDX_W bits.
- start asserted while busy: ignored, with no err_len.
- start in the same cycle as DONE: ignored (busy is still 1).
- x_valid in LOAD_K, FLUSH or DONE, and k_valid outside LOAD_K: not accepted, no strobes.

Decomposition:
- Shared package conv1d_pkg holds:
  - the state enum (IDLE..DONE);
  - the TAPS, MAC_LAT and LEN_W defaults, shared with the kernel store and MAC.
- One natural sub-module, conv1d_valid_pipe: MAC_LAT-deep shift register carrying {valid, last}, with synchronous clear.
- The FSM and counters stay in conv1d_sequencer.

Test Plan:
- Nominal job, N=8, kernel words 0x1, 0x2, 0x3 with continuous valids:
  - k_wr_en pulses 3 times, k_wr_idx 0, 1, 2.
  - Two FILL beats with mac_en=0.
  - 6 mac_en pulses; 6 y_valid pulses, each 2 cycles after its mac_en.
  - y_last on the 6th y_valid; done on the next cycle; busy low the cycle after done.
- Stalled handshakes, N=5, x_valid toggling 1-0-1 and a 3-cycle k_valid gap:
  - No strobes in gap cycles.
  - Exactly 3 mac_en/y_valid pulses; order and idx unchanged.
- Length errors:
  - start with n_samples=2: err_len pulse, busy stays 0.
  - n_samples=3: exactly 1 y_valid, carrying y_last.
- start while busy: second start during RUN → ignored, no err_len, first job output count unchanged.
- Reset mid-job: reset asserted during RUN after 2 mac_en pulses, with y_valid still in flight.
  - Next cycle: all outputs 0, state IDLE.
  - No further y_valid and no done.
  - A new N=4 job then runs correctly (2 outputs).
- Illegal beats:
  - x_valid held high during LOAD_K: no win_shift.
  - k_valid high during RUN: no k_wr_en.
  - Both cases: x_ready/k_ready remain 0 where required.
